// File: rtl/pio_pin_mux.sv
// pio_pin_mux: per-pin ownership multiplexer between PIO cores and the GPIO bank.
// Each pin has an owner core, set through a single-write-per-cycle config port.
// The owner's FSM outputs are merged (highest-index driving FSM wins) and
// registered. Changing a pin's owner opens a tri-stated break-before-make window
// of HANDOVER_CYCLES cycles.
// Optional feature macro: PIO_PIN_MUX_CONFLICT_EN (sticky drive-conflict flags).
module pio_pin_mux #(
    parameter int NUM_CORES       = 4,
    parameter int NUM_FSMS        = 4,
    parameter int NUM_PINS        = 32,
    parameter int HANDOVER_CYCLES = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_we,
    input  logic [$clog2(NUM_PINS)-1:0]            cfg_pin,
    input  logic [$clog2(NUM_CORES)-1:0]           cfg_core,
    input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_output,
    input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_drive,
    input  logic                                   conflict_clr,
    output logic [NUM_PINS-1:0]                    gpio_output,
    output logic [NUM_PINS-1:0]                    gpio_drive,
    output logic [NUM_PINS-1:0]                    pin_busy,
    output logic [NUM_PINS-1:0]                    conflict
);

    localparam int         CW     = $clog2(NUM_CORES);
    localparam int         BW     = NUM_CORES * NUM_FSMS * NUM_PINS;
    localparam logic [3:0] H_LOAD = 4'(HANDOVER_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_HANDOVER = 1'b1
    } state_t;

    state_t          r_state     [NUM_PINS];
    state_t          w_state_nxt [NUM_PINS];
    logic [3:0]      r_cnt       [NUM_PINS];
    logic [3:0]      w_cnt_nxt   [NUM_PINS];
    logic [CW-1:0]   r_owner     [NUM_PINS];
    logic [CW-1:0]   w_owner_nxt [NUM_PINS];
    logic [1:0]      w_mrg       [NUM_PINS];
    logic [NUM_PINS-1:0] w_hit;
    logic                w_wr_ok;
    logic [NUM_PINS-1:0] r_gpio_output;
    logic [NUM_PINS-1:0] r_gpio_drive;
    logic [NUM_PINS-1:0] r_pin_busy;

    // Merge of one core's FSMs onto one pin: returns {drive, value}.
    function automatic logic [1:0] pin_merge(input logic [BW-1:0] f_out,
                                             input logic [BW-1:0] f_drv,
                                             input int            pin,
                                             input logic [CW-1:0] owner);
        logic drv;
        logic val;
        int   idx;
        drv = 1'b0;
        val = 1'b0;
        for (int f = 0; f < NUM_FSMS; f++) begin
            idx = (int'(owner) * NUM_FSMS + f) * NUM_PINS + pin;
            drv = drv | f_drv[idx];
            val = f_drv[idx] ? f_out[idx] : val;
        end
        return {drv, val};
    endfunction

    // Decode the config write: range check plus per-pin hit, dropping no-op same-owner writes.
    always_comb begin
        w_wr_ok = cfg_we && (32'(cfg_pin) < 32'(NUM_PINS)) && (32'(cfg_core) < 32'(NUM_CORES));
        for (int p = 0; p < NUM_PINS; p++) begin
            w_hit[p] = w_wr_ok && (32'(cfg_pin) == 32'(p))
                       && !((cfg_core == r_owner[p]) && (r_state[p] == ST_IDLE));
        end
    end

    // Per-pin ownership FSM next state: writes retarget the owner, handover counts down.
    always_comb begin
        for (int p = 0; p < NUM_PINS; p++) begin
            w_state_nxt[p] = r_state[p];
            w_cnt_nxt[p]   = r_cnt[p];
            w_owner_nxt[p] = r_owner[p];
            case (r_state[p])
                ST_IDLE: begin
                    if (w_hit[p]) begin
                        w_owner_nxt[p] = cfg_core;
                        if (HANDOVER_CYCLES > 0) begin
                            w_state_nxt[p] = ST_HANDOVER;
                            w_cnt_nxt[p]   = H_LOAD;
                        end else begin
                            w_state_nxt[p] = ST_IDLE;
                            w_cnt_nxt[p]   = 4'd0;
                        end
                    end else begin
                        w_state_nxt[p] = ST_IDLE;
                    end
                end
                ST_HANDOVER: begin
                    if (w_hit[p]) begin
                        // Retarget restarts the whole window.
                        w_owner_nxt[p] = cfg_core;
                        w_cnt_nxt[p]   = H_LOAD;
                    end else if (r_cnt[p] <= 4'd1) begin
                        w_state_nxt[p] = ST_IDLE;
                        w_cnt_nxt[p]   = 4'd0;
                    end else begin
                        w_cnt_nxt[p]   = r_cnt[p] - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt[p] = ST_IDLE;
                    w_cnt_nxt[p]   = 4'd0;
                end
            endcase
        end
    end

    // Merge uses the next owner so a zero-length handover switches in the same edge.
    always_comb begin
        for (int p = 0; p < NUM_PINS; p++) begin
            w_mrg[p] = pin_merge(fsm_output, fsm_drive, p, w_owner_nxt[p]);
        end
    end

    // Ownership state registers.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PINS; p++) begin
            if (rst) begin
                r_state[p] <= ST_IDLE;
                r_cnt[p]   <= 4'd0;
                r_owner[p] <= {CW{1'b0}};
            end else begin
                r_state[p] <= w_state_nxt[p];
                r_cnt[p]   <= w_cnt_nxt[p];
                r_owner[p] <= w_owner_nxt[p];
            end
        end
    end

    // Registered pin outputs: tri-state and hold value during handover, else the merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio_output <= {NUM_PINS{1'b0}};
            r_gpio_drive  <= {NUM_PINS{1'b0}};
            r_pin_busy    <= {NUM_PINS{1'b0}};
        end else begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (w_state_nxt[p] == ST_HANDOVER) begin
                    r_gpio_output[p] <= r_gpio_output[p];
                    r_gpio_drive[p]  <= 1'b0;
                    r_pin_busy[p]    <= 1'b1;
                end else begin
                    r_gpio_output[p] <= w_mrg[p][0];
                    r_gpio_drive[p]  <= w_mrg[p][1];
                    r_pin_busy[p]    <= 1'b0;
                end
            end
        end
    end

    assign gpio_output = r_gpio_output;
    assign gpio_drive  = r_gpio_drive;
    assign pin_busy    = r_pin_busy;

`ifdef PIO_PIN_MUX_CONFLICT_EN
    logic [NUM_PINS-1:0] w_conf_set;
    logic [NUM_PINS-1:0] r_conflict;

    // Conflict on a pin: two or more owner FSMs drive it, or any non-owner FSM drives it.
    function automatic logic pin_conflict(input logic [BW-1:0] f_drv,
                                          input int            pin,
                                          input logic [CW-1:0] owner);
        logic own_any;
        logic own_multi;
        logic other_any;
        int   idx;
        own_any   = 1'b0;
        own_multi = 1'b0;
        other_any = 1'b0;
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int f = 0; f < NUM_FSMS; f++) begin
                idx = (c * NUM_FSMS + f) * NUM_PINS + pin;
                if (int'(owner) == c) begin
                    own_multi = own_multi | (own_any & f_drv[idx]);
                    own_any   = own_any | f_drv[idx];
                end else begin
                    other_any = other_any | f_drv[idx];
                end
            end
        end
        return own_multi | other_any;
    endfunction

    // Conflicts are only judged while the pin is settled on its owner.
    always_comb begin
        for (int p = 0; p < NUM_PINS; p++) begin
            w_conf_set[p] = (r_state[p] == ST_IDLE) && pin_conflict(fsm_drive, p, r_owner[p]);
        end
    end

    // Sticky conflict flags; a new conflict beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict <= {NUM_PINS{1'b0}};
        end else if (conflict_clr) begin
            r_conflict <= w_conf_set;
        end else begin
            r_conflict <= r_conflict | w_conf_set;
        end
    end

    assign conflict = r_conflict;
`else
    logic w_unused_clr;
    assign w_unused_clr = conflict_clr;
    assign conflict     = {NUM_PINS{1'b0}};
`endif

endmodule
